bcd_down_timer: RTL

// - Two-digit BCD down-counter (00..99) with load/start/pause control and a terminal-count pulse.
// - Counterpart to the team's free-running up-counter: counts down from a loaded preset instead of up from reset.
// - Sits beside the counter in the sequential-logic set.
// - Drives seven-segment digit logic and signals expiry to a controller.

---
 rtl/bcd_timer_pkg.sv | 23 ++
 rtl/bcd_digit_down.sv | 37 +++
 rtl/bcd_down_timer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared constants, state encoding and digit clamp for the two-digit BCD down-timer.
package bcd_timer_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_PAUSE = ST_PAUSE
    } state_e;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    // Presets above 9 are not valid BCD; saturate them to 9.
    function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit that counts down 9..0 with a combinational borrow out.
module bcd_digit_down
    import bcd_timer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               dec,
    input  logic               load,
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q,
    output logic               borrow
);

    logic [DIGIT_W-1:0] q_q;
    logic [DIGIT_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (dec) begin
            q_d = (q_q == '0) ? BCD_MAX : q_q - DIGIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign borrow = (q_q == '0) && dec;

endmodule

// File: rtl/bcd_down_timer.sv
// Two-digit BCD down-timer with load/start/pause control and a one-cycle done pulse.
// Optional build macro AUTO_RELOAD_EN: reload the captured preset on expiry and keep running.
module bcd_down_timer
    import bcd_timer_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_tens,
    input  logic [DIGIT_W-1:0] load_ones,
    input  logic               start,
    input  logic               pause,
    output logic [DIGIT_W-1:0] cnt_tens,
    output logic [DIGIT_W-1:0] cnt_ones,
    output logic               running,
    output logic               done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_e             state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic               done_q, done_d;
    logic               running_q;
    logic               tick, dec_ones, reload_fire, reload_ok;
    logic               at_zero, at_one;
    logic               digit_load;
    logic [DIGIT_W-1:0] tens_val, ones_val, tens_in, ones_in;
    logic               ones_borrow, tens_borrow_unused;

    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign at_zero = (tens_val == '0) && (ones_val == '0);
    assign at_one  = (tens_val == '0) && (ones_val == DIGIT_W'(1));

`ifdef AUTO_RELOAD_EN
    logic [DIGIT_W-1:0] rl_tens_q, rl_ones_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rl_tens_q <= '0;
            rl_ones_q <= '0;
        end else if (load) begin
            rl_tens_q <= bcd_clamp(load_tens);
            rl_ones_q <= bcd_clamp(load_ones);
        end
    end

    // A zero reload value would just re-expire forever; treat it as no reload.
    assign reload_ok = (rl_tens_q != '0) || (rl_ones_q != '0);
    assign tens_in   = load ? bcd_clamp(load_tens) : rl_tens_q;
    assign ones_in   = load ? bcd_clamp(load_ones) : rl_ones_q;
`else
    assign reload_ok = 1'b0;
    assign tens_in   = bcd_clamp(load_tens);
    assign ones_in   = bcd_clamp(load_ones);
`endif

    assign digit_load = load || reload_fire;

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        done_d      = 1'b0;
        dec_ones    = 1'b0;
        reload_fire = 1'b0;
        if (load) begin
            state_d = S_IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (at_zero) done_d  = 1'b1;
                        else         state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (pause && !start) begin
                        state_d = S_PAUSE;
                    end else begin
                        presc_d = tick ? '0 : presc_q + PW'(1);
                        if (tick) begin
                            if (at_one) begin
                                done_d = 1'b1;
                                if (reload_ok) begin
                                    reload_fire = 1'b1;
                                end else begin
                                    dec_ones = 1'b1;
                                    state_d  = S_IDLE;
                                end
                            end else begin
                                dec_ones = 1'b1;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (start) state_d = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
            running_q <= (state_d == S_RUN);
        end
    end

    bcd_digit_down u_ones (
        .clk    (clk),
        .reset  (reset),
        .dec    (dec_ones),
        .load   (digit_load),
        .d      (ones_in),
        .q      (ones_val),
        .borrow (ones_borrow)
    );

    // Tens only moves on a ones borrow; its own borrow would mean 00 -> 99, which never happens.
    bcd_digit_down u_tens (
        .clk    (clk),
        .reset  (reset),
        .dec    (ones_borrow),
        .load   (digit_load),
        .d      (tens_in),
        .q      (tens_val),
        .borrow (tens_borrow_unused)
    );

    assign cnt_tens = tens_val;
    assign cnt_ones = ones_val;
    assign running  = running_q;
    assign done     = done_q;

endmodule
